// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM control sequencer
//
// Purpose: steps one instruction at a time through FETCH, DECODE, EXEC and
// (for LW/SW) MEM, time-sharing a single memory port between instruction
// fetch and data access and producing per-state datapath strobes.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   opcode[2:0]        IR[15:13], valid from DECODE onward
//   eq                 ALU equality result, used by BEQ in EXEC
//   mem_ack            memory completion for the current request
//   mem_req/we/sel     memory request, write enable, address source (1 = ALU)
//   ir_we, pc_we       IR load and PC update strobes
//   func_alu, mux_*    ALU function and datapath mux selects
//   we_rf              register file write enable
//   instr_done         one-cycle retire pulse
//   err                sticky memory-timeout flag (ERROR state)
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       eq,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] func_alu,
    output logic       mux_alu1,
    output logic       mux_alu2,
    output logic [1:0] mux_pc,
    output logic       mux_rf,
    output logic [1:0] mux_tgt,
    output logic       we_rf,
    output logic       instr_done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_NAND  = 2'b01;
    localparam logic [1:0] ALU_PASS1 = 2'b10;
    localparam logic [1:0] ALU_EQ    = 2'b11;

    localparam logic [1:0] PC_NEXT   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] TGT_ALU  = 2'b01;
    localparam logic [1:0] TGT_DMEM = 2'b10;
    localparam logic [1:0] TGT_PC   = 2'b11;

    // Counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LIMIT_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT_INT);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             limit_hit;

    // ALU controls decoded from opcode; shared by EXEC and MEM so that
    // the address computed in EXEC stays stable while MEM is waiting.
    logic [1:0] alu_func;
    logic       alu_sel1;
    logic       alu_sel2;
    logic       rf_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign limit_hit = TIMEOUT_EN && (cnt_q == CNT_LIMIT);

    always_comb begin
        alu_func = ALU_ADD;
        alu_sel1 = 1'b0;
        alu_sel2 = 1'b0;
        rf_sel   = 1'b0;
        case (opcode)
            OP_ADD:  alu_func = ALU_ADD;
            OP_ADDI: begin alu_func = ALU_ADD; alu_sel2 = 1'b1; end
            OP_NAND: alu_func = ALU_NAND;
            OP_LUI:  begin alu_func = ALU_PASS1; alu_sel1 = 1'b1; end
            OP_LW:   begin alu_func = ALU_ADD; alu_sel2 = 1'b1; end
            OP_SW:   begin alu_func = ALU_ADD; alu_sel2 = 1'b1; rf_sel = 1'b1; end
            OP_BEQ:  begin alu_func = ALU_EQ; rf_sel = 1'b1; end
            OP_JALR: alu_func = ALU_PASS1;
            default: alu_func = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        func_alu   = 2'b00;
        mux_alu1   = 1'b0;
        mux_alu2   = 1'b0;
        mux_pc     = 2'b00;
        mux_rf     = 1'b0;
        mux_tgt    = 2'b00;
        we_rf      = 1'b0;
        instr_done = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (limit_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                func_alu = alu_func;
                mux_alu1 = alu_sel1;
                mux_alu2 = alu_sel2;
                mux_rf   = rf_sel;
                case (opcode)
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        pc_we      = 1'b1;
                        mux_pc     = eq ? PC_BRANCH : PC_NEXT;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_JALR: begin
                        we_rf      = 1'b1;
                        mux_tgt    = TGT_PC;
                        pc_we      = 1'b1;
                        mux_pc     = PC_JUMP;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: begin
                        we_rf      = 1'b1;
                        mux_tgt    = TGT_ALU;
                        pc_we      = 1'b1;
                        mux_pc     = PC_NEXT;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_sel  = 1'b1;
                mem_we   = (opcode == OP_SW);
                func_alu = alu_func;
                mux_alu1 = alu_sel1;
                mux_alu2 = alu_sel2;
                mux_rf   = rf_sel;
                if (mem_ack) begin
                    if (opcode == OP_LW) begin
                        we_rf   = 1'b1;
                        mux_tgt = TGT_DMEM;
                    end
                    pc_we      = 1'b1;
                    mux_pc     = PC_NEXT;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (limit_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                err = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset blanks every output in the cycle it is asserted, so an
        // in-flight request is simply dropped.
        if (rst) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            mem_sel    = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            func_alu   = 2'b00;
            mux_alu1   = 1'b0;
            mux_alu2   = 1'b0;
            mux_pc     = 2'b00;
            mux_rf     = 1'b0;
            mux_tgt    = 2'b00;
            we_rf      = 1'b0;
            instr_done = 1'b0;
            err        = 1'b0;
        end
    end

    // Counter restarts whenever the state changes (entry into FETCH/MEM)
    // and counts cycles spent waiting for mem_ack.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       eq;
    logic       mem_ack;
    logic       mem_req, mem_we, mem_sel, ir_we, pc_we;
    logic [1:0] func_alu;
    logic       mux_alu1, mux_alu2;
    logic [1:0] mux_pc;
    logic       mux_rf;
    logic [1:0] mux_tgt;
    logic       we_rf, instr_done, err;

    int checks;
    int errors;

    multicycle_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .eq         (eq),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .func_alu   (func_alu),
        .mux_alu1   (mux_alu1),
        .mux_alu2   (mux_alu2),
        .mux_pc     (mux_pc),
        .mux_rf     (mux_rf),
        .mux_tgt    (mux_tgt),
        .we_rf      (we_rf),
        .instr_done (instr_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: req we sel ir_we pc_we func[2] a1 a2 pc[2] rf tgt[2] we_rf done err
    logic [17:0] outs;
    assign outs = {mem_req, mem_we, mem_sel, ir_we, pc_we, func_alu, mux_alu1,
                   mux_alu2, mux_pc, mux_rf, mux_tgt, we_rf, instr_done, err};

    // Hand-written expected bundles for each state/opcode situation.
    localparam logic [17:0] E_ZERO      = 18'b0_0_0_0_0_00_0_0_00_0_00_0_0_0;
    localparam logic [17:0] E_FETCH_W   = 18'b1_0_0_0_0_00_0_0_00_0_00_0_0_0;
    localparam logic [17:0] E_FETCH_A   = 18'b1_0_0_1_0_00_0_0_00_0_00_0_0_0;
    localparam logic [17:0] E_DECODE    = 18'b0_0_0_0_0_00_0_0_00_0_00_0_0_0;
    localparam logic [17:0] E_EX_ADD    = 18'b0_0_0_0_1_00_0_0_01_0_01_1_1_0;
    localparam logic [17:0] E_EX_ADDI   = 18'b0_0_0_0_1_00_0_1_01_0_01_1_1_0;
    localparam logic [17:0] E_EX_NAND   = 18'b0_0_0_0_1_01_0_0_01_0_01_1_1_0;
    localparam logic [17:0] E_EX_LUI    = 18'b0_0_0_0_1_10_1_0_01_0_01_1_1_0;
    localparam logic [17:0] E_EX_JALR   = 18'b0_0_0_0_1_10_0_0_11_0_11_1_1_0;
    localparam logic [17:0] E_EX_BEQ_T  = 18'b0_0_0_0_1_11_0_0_10_1_00_0_1_0;
    localparam logic [17:0] E_EX_BEQ_N  = 18'b0_0_0_0_1_11_0_0_01_1_00_0_1_0;
    localparam logic [17:0] E_EX_LW     = 18'b0_0_0_0_0_00_0_1_00_0_00_0_0_0;
    localparam logic [17:0] E_MEM_LW_W  = 18'b1_0_1_0_0_00_0_1_00_0_00_0_0_0;
    localparam logic [17:0] E_MEM_LW_A  = 18'b1_0_1_0_1_00_0_1_01_0_10_1_1_0;
    localparam logic [17:0] E_EX_SW     = 18'b0_0_0_0_0_00_0_1_00_1_00_0_0_0;
    localparam logic [17:0] E_MEM_SW_A  = 18'b1_1_1_0_1_00_0_1_01_1_00_0_1_0;
    localparam logic [17:0] E_ERROR     = 18'b0_0_0_0_0_00_0_0_00_0_00_0_0_1;

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance to just after the next edge,
    // where the caller may change inputs for the following cycle.
    task automatic tick(input string tag, input logic [17:0] exp);
        @(negedge clk);
        check(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        opcode  = 3'b000;
        eq      = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        tick("reset_outputs", E_ZERO);
        rst = 1'b0;

        // ADD with mem_ack tied high: FETCH/DECODE/EXEC repeating.
        for (int i = 0; i < 2; i++) begin
            tick("add_fetch", E_FETCH_A);
            tick("add_decode", E_DECODE);
            tick("add_exec", E_EX_ADD);
        end

        opcode = 3'b001;
        tick("addi_fetch", E_FETCH_A);
        tick("addi_decode", E_DECODE);
        tick("addi_exec", E_EX_ADDI);
        opcode = 3'b010;
        tick("nand_fetch", E_FETCH_A);
        tick("nand_decode", E_DECODE);
        tick("nand_exec", E_EX_NAND);
        opcode = 3'b011;
        tick("lui_fetch", E_FETCH_A);
        tick("lui_decode", E_DECODE);
        tick("lui_exec", E_EX_LUI);
        opcode = 3'b111;
        tick("jalr_fetch", E_FETCH_A);
        tick("jalr_decode", E_DECODE);
        tick("jalr_exec", E_EX_JALR);

        // LW, ack arrives in the third MEM cycle: 6 cycles total.
        opcode = 3'b100;
        tick("lw_fetch", E_FETCH_A);
        mem_ack = 1'b0;
        tick("lw_decode", E_DECODE);
        tick("lw_exec", E_EX_LW);
        tick("lw_mem_wait1", E_MEM_LW_W);
        tick("lw_mem_wait2", E_MEM_LW_W);
        mem_ack = 1'b1;
        tick("lw_mem_ack", E_MEM_LW_A);

        // BEQ taken, then not taken.
        opcode = 3'b110;
        eq = 1'b1;
        tick("beq1_fetch", E_FETCH_A);
        tick("beq1_decode", E_DECODE);
        tick("beq_taken_exec", E_EX_BEQ_T);
        eq = 1'b0;
        tick("beq2_fetch", E_FETCH_A);
        tick("beq2_decode", E_DECODE);
        tick("beq_not_taken_exec", E_EX_BEQ_N);

        // SW zero-wait.
        opcode = 3'b101;
        tick("sw_fetch", E_FETCH_A);
        tick("sw_decode", E_DECODE);
        tick("sw_exec", E_EX_SW);
        tick("sw_mem_ack", E_MEM_SW_A);

        // Ack on the 8th FETCH cycle still completes the handshake.
        opcode = 3'b000;
        mem_ack = 1'b0;
        for (int i = 0; i < 7; i++) tick("limit_fetch_wait", E_FETCH_W);
        mem_ack = 1'b1;
        tick("limit_fetch_ack", E_FETCH_A);
        tick("limit_decode", E_DECODE);
        tick("limit_exec", E_EX_ADD);

        // No ack for 8 FETCH cycles: ERROR, which ignores mem_ack.
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) tick("timeout_fetch_wait", E_FETCH_W);
        tick("timeout_error", E_ERROR);
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) tick("error_held", E_ERROR);
        rst = 1'b1;
        tick("error_reset", E_ZERO);
        rst = 1'b0;
        mem_ack = 1'b0;
        tick("after_error_fetch", E_FETCH_W);

        // Reset in the middle of an LW MEM wait.
        mem_ack = 1'b1;
        opcode = 3'b100;
        tick("rstmem_fetch", E_FETCH_A);
        tick("rstmem_decode", E_DECODE);
        tick("rstmem_exec", E_EX_LW);
        mem_ack = 1'b0;
        tick("rstmem_mem_wait", E_MEM_LW_W);
        rst = 1'b1;
        tick("rstmem_reset", E_ZERO);
        rst = 1'b0;
        tick("rstmem_fetch_after", E_FETCH_W);
        tick("rstmem_fetch_after2", E_FETCH_W);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
